// File: rtl/detect_pkg.sv
// detect_pkg: drive-type codes, detection constants and voter states shared by the interface-detection blocks
package detect_pkg;
    localparam logic [1:0]  DRIVE_UNKNOWN         = 2'd0;
    localparam logic [1:0]  DRIVE_FLOPPY          = 2'd1;
    localparam logic [1:0]  DRIVE_HDD             = 2'd2;
    localparam logic [26:0] SETTLE_CLKS_DEFAULT   = 27'd30_000_000;
    localparam logic [7:0]  CONF_PENALTY_DISAGREE = 8'd64;

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_LAUNCH, S_WAIT, S_DRAIN, S_ACCUM, S_DECIDE, S_DIVIDE, S_DONE
    } det_state_t;

    function automatic logic [7:0] disagree_conf(input logic [7:0] c);
        return c > CONF_PENALTY_DISAGREE ? c - CONF_PENALTY_DISAGREE : 8'd0;
    endfunction
endpackage

// File: rtl/index_avg_div.sv
// index_avg_div: fixed 30-cycle restoring divider turning a period sum and vote count into a mean period
module index_avg_div (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        div_start,
    input  logic [29:0] dividend,
    input  logic [2:0]  divisor,
    output logic        div_done,
    output logic [26:0] quotient
);
    logic [29:0] quo_q;
    logic [2:0]  rem_q, rem_d, dvs_q, diff;
    logic [4:0]  cnt_q;
    logic        busy_q, done_q, ge;
    logic [3:0]  trial;

    // remainder stays below the divisor, so the difference always fits in 3 bits
    always_comb begin
        trial = {rem_q, quo_q[29]};
        diff  = trial[2:0] - dvs_q;
        ge    = trial >= {1'b0, dvs_q};
        rem_d = ge ? diff : trial[2:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (div_start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= busy_q && cnt_q == 5'd29;
            if (busy_q) begin
                quo_q  <= {quo_q[28:0], ge};
                rem_q  <= rem_d;
                cnt_q  <= cnt_q + 5'd1;
                busy_q <= cnt_q != 5'd29;
            end
        end
    end

    assign div_done = done_q;
    assign quotient = dvs_q == 3'd0 ? '0 : quo_q[26:0];
endmodule

// File: rtl/index_detect_voter.sv
// index_detect_voter: spins up the motor, runs repeated index-period trials and majority-votes floppy vs HDD
module index_detect_voter
    import detect_pkg::*;
#(
    parameter int unsigned NUM_TRIALS    = 3,
    parameter logic [7:0]  CONF_MIN      = 8'd128,
    parameter logic [26:0] SETTLE_CLKS   = SETTLE_CLKS_DEFAULT,
    parameter logic [26:0] TRIAL_TIMEOUT = 27'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        det_start,
    input  logic        det_abort,
    output logic        det_busy,
    output logic        det_done,
    output logic        motor_on,
    output logic        cnt_start,
    output logic        cnt_abort,
    output logic [26:0] cnt_timeout,
    input  logic        cnt_done,
    input  logic        cnt_busy,
    input  logic [26:0] cnt_period,
    input  logic [1:0]  cnt_class,
    input  logic [7:0]  cnt_confidence,
    output logic [1:0]  drive_type,
    output logic        type_valid,
    output logic [7:0]  final_confidence,
    output logic [26:0] avg_period,
    output logic [2:0]  trials_run,
    output logic [2:0]  votes_floppy,
    output logic [2:0]  votes_hdd
);
    localparam logic [2:0] NT   = 3'(NUM_TRIALS);
    localparam logic [2:0] HALF = 3'(NUM_TRIALS / 2);

    det_state_t  state_q, state_d;
    logic [26:0] settle_q, settle_d, per_q, per_d, avg_q, avg_d, quotient;
    logic [1:0]  cls_q, cls_d, type_q, type_d;
    logic [7:0]  conf_q, conf_d, fconf_q, fconf_d, minf_q, minf_d, minh_q, minh_d, win_min;
    logic [2:0]  trials_q, trials_d, vf_q, vf_d, vh_q, vh_d, win_votes;
    logic [29:0] sumf_q, sumf_d, sumh_q, sumh_d;
    logic        valid_q, valid_d, start_q, start_d, abort_q, abort_d;
    logic        div_start, div_done, vote, win_f, win_h;

    assign win_f     = vf_q > HALF;
    assign win_h     = vh_q > HALF;
    assign vote      = conf_q >= CONF_MIN && (cls_q == DRIVE_FLOPPY || cls_q == DRIVE_HDD);
    assign win_votes = type_q == DRIVE_FLOPPY ? vf_q : vh_q;
    assign win_min   = type_q == DRIVE_FLOPPY ? minf_q : minh_q;

    index_avg_div u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .div_start(div_start),
        .dividend (win_f ? sumf_q : sumh_q),
        .divisor  (win_f ? vf_q : vh_q),
        .div_done (div_done),
        .quotient (quotient)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        per_d     = per_q;
        cls_d     = cls_q;
        conf_d    = conf_q;
        trials_d  = trials_q;
        vf_d      = vf_q;
        vh_d      = vh_q;
        sumf_d    = sumf_q;
        sumh_d    = sumh_q;
        minf_d    = minf_q;
        minh_d    = minh_q;
        type_d    = type_q;
        fconf_d   = fconf_q;
        avg_d     = avg_q;
        valid_d   = valid_q;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: if (det_start) begin
                state_d  = S_SETTLE;
                settle_d = '0;
                trials_d = '0;
                vf_d     = '0;
                vh_d     = '0;
                sumf_d   = '0;
                sumh_d   = '0;
                minf_d   = 8'hFF;
                minh_d   = 8'hFF;
                type_d   = DRIVE_UNKNOWN;
                fconf_d  = '0;
                avg_d    = '0;
                valid_d  = 1'b0;
            end
            S_SETTLE: begin
                settle_d = settle_q + 27'd1;
                state_d  = det_abort ? S_DONE : settle_q == SETTLE_CLKS - 27'd1 ? S_LAUNCH : S_SETTLE;
            end
            S_LAUNCH: begin
                start_d = !det_abort && !cnt_busy;
                state_d = det_abort ? S_DECIDE : cnt_busy ? S_LAUNCH : S_WAIT;
            end
            // a result arriving with the abort is already complete, so no counter abort is needed
            S_WAIT: if (det_abort) begin
                abort_d = !cnt_done;
                state_d = cnt_done ? S_DECIDE : S_DRAIN;
            end else if (cnt_done) begin
                per_d   = cnt_period;
                cls_d   = cnt_class;
                conf_d  = cnt_confidence;
                state_d = S_ACCUM;
            end
            S_DRAIN: state_d = cnt_done ? S_DECIDE : S_DRAIN;
            S_ACCUM: begin
                trials_d = trials_q + 3'd1;
                if (vote && cls_q == DRIVE_FLOPPY) begin
                    vf_d   = vf_q + 3'd1;
                    sumf_d = sumf_q + {3'b0, per_q};
                    minf_d = conf_q < minf_q ? conf_q : minf_q;
                end
                if (vote && cls_q == DRIVE_HDD) begin
                    vh_d   = vh_q + 3'd1;
                    sumh_d = sumh_q + {3'b0, per_q};
                    minh_d = conf_q < minh_q ? conf_q : minh_q;
                end
                state_d = (vf_d > HALF || vh_d > HALF || trials_d == NT) ? S_DECIDE : S_LAUNCH;
            end
            S_DECIDE: begin
                type_d    = win_f ? DRIVE_FLOPPY : win_h ? DRIVE_HDD : DRIVE_UNKNOWN;
                div_start = win_f || win_h;
                state_d   = div_start ? S_DIVIDE : S_DONE;
            end
            S_DIVIDE: if (div_done) begin
                avg_d   = quotient;
                fconf_d = win_votes == trials_q ? win_min : disagree_conf(win_min);
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE) valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            per_q    <= '0;
            cls_q    <= '0;
            conf_q   <= '0;
            trials_q <= '0;
            vf_q     <= '0;
            vh_q     <= '0;
            sumf_q   <= '0;
            sumh_q   <= '0;
            minf_q   <= 8'hFF;
            minh_q   <= 8'hFF;
            type_q   <= DRIVE_UNKNOWN;
            fconf_q  <= '0;
            avg_q    <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            per_q    <= per_d;
            cls_q    <= cls_d;
            conf_q   <= conf_d;
            trials_q <= trials_d;
            vf_q     <= vf_d;
            vh_q     <= vh_d;
            sumf_q   <= sumf_d;
            sumh_q   <= sumh_d;
            minf_q   <= minf_d;
            minh_q   <= minh_d;
            type_q   <= type_d;
            fconf_q  <= fconf_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
        end
    end

    assign det_busy         = state_q != S_IDLE && state_q != S_DONE;
    assign motor_on         = det_busy;
    assign det_done         = state_q == S_DONE;
    assign cnt_start        = start_q;
    assign cnt_abort        = abort_q;
    assign cnt_timeout      = TRIAL_TIMEOUT;
    assign drive_type       = type_q;
    assign type_valid       = valid_q;
    assign final_confidence = fconf_q;
    assign avg_period       = avg_q;
    assign trials_run       = trials_q;
    assign votes_floppy     = vf_q;
    assign votes_hdd        = vh_q;
endmodule

// File: tb/tb_index_detect_voter.sv
// tb_index_detect_voter: randomized and directed detections scored against a trial-list reference model
module tb_index_detect_voter;
    localparam int NT = 3;
    localparam logic [26:0] TMO = 27'd4321;

    typedef struct packed {
        logic [1:0]  cls;
        logic [26:0] per;
        logic [7:0]  conf;
    } resp_t;

    typedef struct packed {
        logic [1:0]  dtype;
        logic [7:0]  conf;
        logic [26:0] avg;
        logic [2:0]  trials;
        logic [2:0]  vf;
        logic [2:0]  vh;
        int          starts;
        int          aborts;
    } exp_t;

    logic        clk, reset_n, det_start, det_abort, det_abort_drv, det_abort_sync;
    logic        det_busy, det_done, motor_on, cnt_start, cnt_abort;
    logic [26:0] cnt_timeout, cnt_period, avg_period;
    logic        cnt_done, cnt_busy, type_valid;
    logic [1:0]  cnt_class, drive_type;
    logic [7:0]  cnt_confidence, final_confidence;
    logic [2:0]  trials_run, votes_floppy, votes_hdd;

    int    checks = 0, errors = 0;
    resp_t resp[$];
    exp_t  exp_q[$];
    int    trial_idx = 0, sync_idx = -1, n_start = 0, n_abort = 0;
    logic  prev_busy = 1'b0;

    assign det_abort = det_abort_drv | det_abort_sync;

    index_detect_voter #(
        .NUM_TRIALS(NT), .CONF_MIN(8'd128), .SETTLE_CLKS(27'd20), .TRIAL_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .det_start(det_start), .det_abort(det_abort),
        .det_busy(det_busy), .det_done(det_done), .motor_on(motor_on),
        .cnt_start(cnt_start), .cnt_abort(cnt_abort), .cnt_timeout(cnt_timeout),
        .cnt_done(cnt_done), .cnt_busy(cnt_busy), .cnt_period(cnt_period),
        .cnt_class(cnt_class), .cnt_confidence(cnt_confidence),
        .drive_type(drive_type), .type_valid(type_valid), .final_confidence(final_confidence),
        .avg_period(avg_period), .trials_run(trials_run),
        .votes_floppy(votes_floppy), .votes_hdd(votes_hdd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic resp_t mk(input int c, input int p, input int f);
        mk.cls  = 2'(c);
        mk.per  = 27'(p);
        mk.conf = 8'(f);
    endfunction

    // mode: 0 normal, 1 abort mid-trial, 2 abort together with the trial's done, 3 abort while settling
    function automatic exp_t model(input resp_t t[NT], input int mode, input int abort_at);
        exp_t   e;
        int     v[4], mn[4];
        longint s[4];
        e = '0;
        for (int k = 0; k < 4; k++) begin
            v[k] = 0; mn[k] = 255; s[k] = 0;
        end
        if (mode == 3) return e;
        for (int i = 0; i < NT; i++) begin
            if (mode != 0 && i == abort_at) break;
            e.trials = e.trials + 3'd1;
            if (t[i].conf >= 128 && (t[i].cls == 1 || t[i].cls == 2)) begin
                v[t[i].cls]++;
                s[t[i].cls] += t[i].per;
                if (t[i].conf < mn[t[i].cls]) mn[t[i].cls] = t[i].conf;
            end
            if (v[1] > NT / 2 || v[2] > NT / 2) break;
        end
        e.starts = mode == 0 ? int'(e.trials) : abort_at + 1;
        e.aborts = mode == 1 ? 1 : 0;
        e.vf = 3'(v[1]);
        e.vh = 3'(v[2]);
        for (int w = 1; w <= 2; w++)
            if (v[w] > NT / 2) begin
                e.dtype = 2'(w);
                e.avg   = 27'(s[w] / v[w]);
                e.conf  = v[w] == int'(e.trials) ? 8'(mn[w]) : mn[w] > 64 ? 8'(mn[w] - 64) : 8'd0;
            end
        return e;
    endfunction

    // counter stand-in: random measurement time, optional busy tail after done, fast reply to abort
    initial begin : counter_model
        int run_left, tail_left;
        bit aborted;
        resp_t cur;
        run_left = 0; tail_left = 0; aborted = 0; cur = '0;
        cnt_done = 0; cnt_busy = 0; cnt_period = '0; cnt_class = '0; cnt_confidence = '0;
        det_abort_sync = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt_done = 1'b0;
            det_abort_sync = 1'b0;
            if (!reset_n) begin
                run_left = 0; tail_left = 0; cnt_busy = 0;
            end else if (cnt_start) begin
                cnt_busy = 1; aborted = 0; run_left = $urandom_range(4, 10);
                cur = resp.size() > 0 ? resp.pop_front() : '0;
                trial_idx++;
            end else if (run_left > 0) begin
                if (cnt_abort) begin aborted = 1; run_left = 1; end
                run_left--;
                if (run_left == 0) begin
                    cnt_done = 1;
                    tail_left = $urandom_range(0, 3);
                    cnt_busy = tail_left != 0;
                    {cnt_class, cnt_period, cnt_confidence} = aborted ? {2'd2, 27'd1234, 8'd255} : cur;
                    if (trial_idx - 1 == sync_idx) det_abort_sync = 1'b1;
                end
            end else if (tail_left > 0) begin
                tail_left--;
                cnt_busy = tail_left != 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (det_start) begin n_start = 0; n_abort = 0; end
        if (cnt_start) begin
            n_start++;
            chk("start_while_busy", prev_busy, 0);
        end
        if (cnt_abort) n_abort++;
        if (det_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("drive_type", drive_type, e.dtype);
                chk("final_confidence", final_confidence, e.conf);
                chk("avg_period", avg_period, e.avg);
                chk("trials_run", trials_run, e.trials);
                chk("votes_floppy", votes_floppy, e.vf);
                chk("votes_hdd", votes_hdd, e.vh);
                chk("cnt_start_pulses", n_start, e.starts);
                chk("cnt_abort_pulses", n_abort, e.aborts);
                chk("valid_at_done", type_valid, 1);
                chk("motor_off_at_done", motor_on, 0);
                chk("busy_off_at_done", det_busy, 0);
            end
        end
        prev_busy = cnt_busy;
    end

    task automatic run_det(input resp_t t[NT], input int mode, input int abort_at);
        bit seen;
        exp_q.push_back(model(t, mode, abort_at));
        resp.delete();
        for (int i = 0; i < NT; i++) resp.push_back(t[i]);
        trial_idx = 0;
        sync_idx = mode == 2 ? abort_at : -1;
        @(posedge clk); #1 det_start = 1'b1;
        @(posedge clk); #1 det_start = 1'b0;
        if (mode == 1) begin
            for (int k = 0; k < 2000 && trial_idx < abort_at + 1; k++) begin
                @(posedge clk); #2;
            end
            @(posedge clk); #1 det_abort_drv = 1'b1;
            @(posedge clk); #1 det_abort_drv = 1'b0;
        end else if (mode == 3) begin
            repeat (5) @(posedge clk);
            #1 det_abort_drv = 1'b1;
            @(posedge clk); #1 det_abort_drv = 1'b0;
        end
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = det_done;
        end
        chk("done_within_bound", seen, 1);
        @(negedge clk);
        chk("done_single_cycle", det_done, 0);
        chk("valid_holds", type_valid, seen);
    endtask

    initial begin
        resp_t t[NT];
        int m, a;
        reset_n = 1'b0; det_start = 1'b0; det_abort_drv = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {det_busy, det_done, motor_on, cnt_start, cnt_abort, drive_type, type_valid,
            final_confidence, avg_period, trials_run, votes_floppy, votes_hdd}, 0);
        chk("cnt_timeout", cnt_timeout, TMO);
        reset_n = 1'b1;

        t = '{mk(2, 5_000_000, 255), mk(2, 5_000_000, 255), mk(2, 5_000_000, 255)};
        run_det(t, 0, 0);
        t = '{mk(1, 60_000_000, 255), mk(2, 5_000_000, 255), mk(1, 50_000_000, 200)};
        run_det(t, 0, 0);

        @(posedge clk); #1 det_start = 1'b1;
        @(posedge clk); #1 det_start = 1'b0;
        repeat (4) @(posedge clk);
        #3 chk("motor_before_reset", motor_on, 1);
        reset_n = 1'b0;
        #1 chk("async_reset_outputs", {det_busy, det_done, motor_on, cnt_start, cnt_abort, drive_type,
            type_valid, final_confidence, avg_period, trials_run, votes_floppy, votes_hdd}, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        t = '{mk(2, 7_000_001, 250), mk(2, 7_000_000, 240), mk(1, 1, 255)};
        run_det(t, 0, 0);
        t = '{mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0)};
        run_det(t, 0, 0);
        t = '{mk(2, 5_000_000, 100), mk(2, 5_000_000, 255), mk(2, 5_000_000, 255)};
        run_det(t, 0, 0);
        t = '{mk(2, 5_000_000, 255), mk(2, 5_000_000, 255), mk(2, 5_000_000, 255)};
        run_det(t, 1, 1);
        run_det(t, 2, 1);
        run_det(t, 3, 0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NT; i++)
                t[i] = mk($urandom_range(0, 3), $urandom_range(1, 134217727),
                          $urandom_range(0, 1) ? 255 : $urandom_range(0, 255));
            m = $urandom_range(0, 9);
            m = m < 7 ? 0 : m - 6;
            a = $urandom_range(0, 1);
            run_det(t, m, a);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
